// File: rtl/uart_telemetry_pkg.sv
// Shared constants, FSM state type and helpers for the telemetry UART transmitter.
package uart_telemetry_pkg;

    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SEL,
        S_CONV,
        S_TAG,
        S_COLON,
        S_DIGITS,
        S_SEP,
        S_EOL,
        S_DONE
    } tele_state_t;

    // Decimal digit count of the largest w-bit unsigned value, i.e. ceil(log10(2^w)).
    function automatic int unsigned clog10(input int unsigned w);
        longint unsigned v;
        int unsigned     d;
        v = (64'd1 << w) - 64'd1;
        d = 1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer: start bit, 8 data bits LSB first, one stop bit.
module uart_tx_byte #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    logic             active;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;

    assign ready = ~active;

    // Shift out one frame; each bit holds for DIV clocks, line returns to idle high.
    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
        end else if (!active) begin
            if (start) begin
                active   <= 1'b1;
                tx       <= 1'b0;
                shreg    <= {1'b1, data};
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (baud_cnt == CNT_W'(DIV - 1)) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                active <= 1'b0;
            end else begin
                tx      <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
                bit_idx <= bit_idx + 4'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_telemetry_tx.sv
// Periodic multi-channel telemetry formatter: "<tag>:<decimal>" per channel over UART 8N1.
module uart_telemetry_tx
    import uart_telemetry_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned VAL_W       = 10,
    parameter int unsigned PERIOD_CLKS = 100_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    force_send,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [NUM_CH*8-1:0]     ch_tag,
    input  logic [NUM_CH*VAL_W-1:0] ch_value,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int unsigned DIGITS = clog10(VAL_W);
    localparam int unsigned BCD_W  = DIGITS * 4;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PER_W  = $clog2(PERIOD_CLKS + 1);
    localparam int unsigned CONV_W = $clog2(VAL_W + 1);
    localparam int unsigned DIG_W  = $clog2(DIGITS + 1);

    tele_state_t              state;
    logic [PER_W-1:0]         per_cnt;
    logic                     period_tick;
    logic                     trigger;
    logic [NUM_CH-1:0]        pend;
    logic [NUM_CH*8-1:0]      snap_tag;
    logic [NUM_CH*VAL_W-1:0]  snap_value;
    logic [CH_W-1:0]          cur_ch;
    logic [CH_W-1:0]          sel_idx;
    logic                     sel_any;
    logic [BCD_W-1:0]         bcd;
    logic [BCD_W-1:0]         bcd_adj;
    logic [VAL_W-1:0]         bin;
    logic [CONV_W-1:0]        conv_cnt;
    logic [DIG_W-1:0]         dig_idx;
    logic [DIG_W-1:0]         lead;
    logic [3:0]               cur_digit;
    logic                     second;
    logic                     byte_valid;
    logic [7:0]               tx_data;
    logic                     ser_ready;
    logic                     ser_start;

    assign period_tick = enable && (per_cnt == PER_W'(PERIOD_CLKS - 1));
    assign trigger     = period_tick | force_send;
    assign ser_start   = byte_valid & ser_ready;
    assign cur_digit   = bcd[4*dig_idx +: 4];

    // Free-running frame period counter, paused while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (enable) begin
            per_cnt <= period_tick ? '0 : per_cnt + 1'b1;
        end
    end

    // Lowest-index channel still pending in this frame.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pend[i] && !sel_any) begin
                sel_idx = CH_W'(i);
                sel_any = 1'b1;
            end
        end
    end

    // Double-dabble correction step and leading-zero scan over the BCD register.
    always_comb begin
        bcd_adj = bcd;
        lead    = '0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            if (d > 0 && bcd[4*d +: 4] != 4'd0) begin
                lead = DIG_W'(d);
            end
        end
    end

    // Frame sequencer; every emit state holds byte_valid until the serializer takes the byte.
    // The final conversion cycle preloads the tag byte so the first start bit is not delayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            pend       <= '0;
            snap_tag   <= '0;
            snap_value <= '0;
            cur_ch     <= '0;
            bcd        <= '0;
            bin        <= '0;
            conv_cnt   <= '0;
            dig_idx    <= '0;
            second     <= 1'b0;
            byte_valid <= 1'b0;
            tx_data    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (trigger && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (trigger && ch_mask != '0) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pend       <= ch_mask;
                    snap_tag   <= ch_tag;
                    snap_value <= ch_value;
                    busy       <= 1'b1;
                    state      <= S_SEL;
                end
                S_SEL: begin
                    if (!sel_any) begin
                        second <= 1'b0;
                        state  <= S_EOL;
                    end else begin
                        cur_ch        <= sel_idx;
                        pend[sel_idx] <= 1'b0;
                        bcd           <= '0;
                        bin           <= snap_value[VAL_W*sel_idx +: VAL_W];
                        conv_cnt      <= '0;
                        state         <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd      <= {bcd_adj[BCD_W-2:0], bin[VAL_W-1]};
                    bin      <= bin << 1;
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_cnt == CONV_W'(VAL_W - 1)) begin
                        tx_data    <= snap_tag[8*cur_ch +: 8];
                        byte_valid <= 1'b1;
                        state      <= S_TAG;
                    end
                end
                S_TAG: begin
                    if (ser_ready) begin
                        byte_valid <= 1'b0;
                        state      <= S_COLON;
                    end
                end
                S_COLON: begin
                    if (!byte_valid) begin
                        tx_data    <= ASC_COLON;
                        byte_valid <= 1'b1;
                    end else if (ser_ready) begin
                        byte_valid <= 1'b0;
                        dig_idx    <= lead;
                        state      <= S_DIGITS;
                    end
                end
                S_DIGITS: begin
                    if (!byte_valid) begin
                        tx_data    <= ASC_ZERO + {4'h0, cur_digit};
                        byte_valid <= 1'b1;
                    end else if (ser_ready) begin
                        byte_valid <= 1'b0;
                        if (dig_idx == '0) begin
                            second <= 1'b0;
                            state  <= S_SEP;
                        end else begin
                            dig_idx <= dig_idx - 1'b1;
                        end
                    end
                end
                S_SEP: begin
                    if (pend == '0) begin
                        state <= S_EOL;
                    end else if (!byte_valid) begin
                        tx_data    <= second ? ASC_SPACE : ASC_COMMA;
                        byte_valid <= 1'b1;
                    end else if (ser_ready) begin
                        byte_valid <= 1'b0;
                        second     <= ~second;
                        if (second) begin
                            state <= S_SEL;
                        end
                    end
                end
                S_EOL: begin
                    if (!byte_valid) begin
                        tx_data    <= second ? ASC_CR : ASC_LF;
                        byte_valid <= 1'b1;
                    end else if (ser_ready) begin
                        byte_valid <= 1'b0;
                        second     <= ~second;
                        if (second) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (ser_ready) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_ser (
        .clk   (clk),
        .reset (reset),
        .start (ser_start),
        .data  (tx_data),
        .tx    (tx),
        .ready (ser_ready)
    );

endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Self-checking bench for uart_telemetry_tx: decodes the UART line and compares frames.
module tb_uart_telemetry_tx;

    localparam int unsigned VAL_W   = 10;
    localparam int unsigned DIV_A   = 4;
    localparam int unsigned DIV_B   = 868;
    localparam int unsigned MAX_LAT = VAL_W + 4;

    typedef struct {
        logic [2:0]  mask;
        logic [29:0] vals;
        string       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, enable, force_a, force_b;
    logic [2:0]  mask_a, mask_b;
    logic [23:0] tag_a, tag_b;
    logic [29:0] val_a, val_b;
    logic        tx_a, busy_a, done_a, ovr_a;
    logic        tx_b, busy_b, done_b, ovr_b;

    int n_vec = 0;
    int n_err = 0;

    vec_t       vecs[$];
    logic [7:0] rxq[$];
    int         rise_cyc[$];
    int         done_cnt  = 0;
    int         frame_err = 0;
    int         cyc       = 0;
    bit         busy_prev = 1'b0;
    bit         rx_act    = 1'b0;
    int         rx_cnt, rx_k;
    logic [7:0] rx_sh;
    logic       samp [0:10*DIV_B-1];

    always #5 clk = ~clk;

    uart_telemetry_tx #(
        .CLK_FREQ    (1_000_000),
        .BAUD        (250_000),
        .NUM_CH      (3),
        .VAL_W       (VAL_W),
        .PERIOD_CLKS (1000)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .force_send (force_a),
        .ch_mask    (mask_a),
        .ch_tag     (tag_a),
        .ch_value   (val_a),
        .tx         (tx_a),
        .busy       (busy_a),
        .frame_done (done_a),
        .overrun    (ovr_a)
    );

    uart_telemetry_tx #(
        .CLK_FREQ    (100_000_000),
        .BAUD        (115_200),
        .NUM_CH      (3),
        .VAL_W       (VAL_W),
        .PERIOD_CLKS (100_000_000)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (1'b0),
        .force_send (force_b),
        .ch_mask    (mask_b),
        .ch_tag     (tag_b),
        .ch_value   (val_b),
        .tx         (tx_b),
        .busy       (busy_b),
        .frame_done (done_b),
        .overrun    (ovr_b)
    );

    task automatic check_val(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic [2:0] m, input logic [9:0] vd, input logic [9:0] vt,
                           input logic [9:0] vh, input string e);
        vec_t v;
        v.mask = m;
        v.vals = {vd, vt, vh};
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic pulse_force_a();
        @(negedge clk);
        force_a = 1'b1;
        @(negedge clk);
        force_a = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_done_seen"}, int'(done_cnt != 0), 1);
    endtask

    task automatic check_frame(input string name, input string exp);
        check_val({name, "_len"}, rxq.size(), exp.len());
        for (int i = 0; i < exp.len() && i < rxq.size(); i++) begin
            check_val($sformatf("%s_byte%0d", name, i), int'(rxq[i]), int'(exp[i]));
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        mask_a = vecs[i].mask;
        val_a  = vecs[i].vals;
        rxq.delete();
        done_cnt = 0;
        @(negedge clk);
        force_a = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            force_a = 1'b0;
        end while (tx_a !== 1'b0 && lat < 60);
        check_val($sformatf("v%0d_latency_ok", i), int'(lat <= MAX_LAT), 1);
        wait_done($sformatf("v%0d", i), 4000);
        repeat (10) @(negedge clk);
        check_frame($sformatf("v%0d", i), vecs[i].exp);
        check_val($sformatf("v%0d_done_count", i), done_cnt, 1);
        check_val($sformatf("v%0d_overrun", i), int'(ovr_a), 0);
        check_val($sformatf("v%0d_busy_after", i), int'(busy_a), 0);
    endtask

    // Line monitor for dut_a: UART receiver, frame_done counter, busy rise timestamps.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done_a === 1'b1) done_cnt++;
            if (busy_a === 1'b1 && !busy_prev) rise_cyc.push_back(cyc);
            busy_prev = (busy_a === 1'b1);
            if (!rx_act) begin
                if (tx_a === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % DIV_A == DIV_A / 2) begin
                    rx_k = rx_cnt / DIV_A;
                    if (rx_k >= 1 && rx_k <= 8) begin
                        rx_sh[rx_k-1] = tx_a;
                    end else if (rx_k == 9) begin
                        if (tx_a !== 1'b1) frame_err++;
                        rxq.push_back(rx_sh);
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] b_bits;
        int         n;
        bit         tx_low, busy_hi;

        reset   = 1'b1;
        enable  = 1'b0;
        force_a = 1'b0;
        force_b = 1'b0;
        mask_a  = 3'b000;
        tag_a   = {8'h44, 8'h54, 8'h48};
        val_a   = '0;
        mask_b  = 3'b001;
        tag_b   = {8'h44, 8'h54, 8'h48};
        val_b   = {10'd0, 10'd0, 10'd58};

        add_vec(3'b011, 10'd123, 10'd25,   10'd58, "H:58, T:25\n\r");
        add_vec(3'b100, 10'd0,   10'd25,   10'd58, "D:0\n\r");
        add_vec(3'b111, 10'd1023, 10'd100, 10'd7,  "H:7, T:100, D:1023\n\r");
        add_vec(3'b101, 10'd10,  10'd0,    10'd9,  "H:9, D:10\n\r");
        add_vec(3'b010, 10'd0,   10'd1000, 10'd0,  "T:1000\n\r");
        add_vec(3'b110, 10'd500, 10'd0,    10'd0,  "T:0, D:500\n\r");
        add_vec(3'b001, 10'd0,   10'd0,    10'd1,  "H:1\n\r");

        repeat (3) @(negedge clk);
        check_val("rst_tx", int'(tx_a), 1);
        check_val("rst_busy", int'(busy_a), 0);
        check_val("rst_frame_done", int'(done_a), 0);
        check_val("rst_overrun", int'(ovr_a), 0);
        check_val("rst_tx_b", int'(tx_b), 1);
        @(negedge clk);
        reset = 1'b0;

        // 115200 baud at 100 MHz: bit timing and order on the leading 'H'
        @(negedge clk);
        force_b = 1'b1;
        @(negedge clk);
        force_b = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("b_start_seen", int'(tx_b === 1'b0), 1);
        for (int i = 0; i < 10 * DIV_B; i++) begin
            samp[i] = tx_b;
            @(negedge clk);
        end
        b_bits = {1'b1, 8'h48, 1'b0};
        for (int k = 0; k < 10; k++) begin
            check_val($sformatf("b_bit%0d_center", k), int'(samp[k*DIV_B + DIV_B/2]), int'(b_bits[k]));
        end
        for (int k = 1; k < 10; k++) begin
            check_val($sformatf("b_bit%0d_last", k-1), int'(samp[k*DIV_B - 1]), int'(b_bits[k-1]));
            check_val($sformatf("b_bit%0d_first", k), int'(samp[k*DIV_B]), int'(b_bits[k]));
        end
        check_val("b_stop_last", int'(samp[10*DIV_B - 1]), 1);

        // Directed frame table on dut_a
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i);
        end

        // Periodic trigger
        mask_a = vecs[1].mask;
        val_a  = vecs[1].vals;
        rise_cyc.delete();
        rxq.delete();
        done_cnt = 0;
        @(negedge clk);
        enable = 1'b1;
        repeat (3600) @(negedge clk);
        enable = 1'b0;
        check_val("per_rises_ge3", int'(rise_cyc.size() >= 3), 1);
        for (int i = 1; i < rise_cyc.size(); i++) begin
            check_val($sformatf("per_interval%0d", i), rise_cyc[i] - rise_cyc[i-1], 1000);
        end
        check_val("per_done_count", done_cnt, rise_cyc.size());
        check_val("per_bytes", rxq.size(), 5 * rise_cyc.size());
        check_val("per_overrun", int'(ovr_a), 0);
        repeat (300) @(negedge clk);
        rise_cyc.delete();
        done_cnt = 0;
        repeat (2500) @(negedge clk);
        check_val("dis_no_frames", rise_cyc.size(), 0);
        pulse_force_a();
        repeat (1500) @(negedge clk);
        check_val("dis_force_frames", rise_cyc.size(), 1);
        check_val("dis_force_done", done_cnt, 1);

        // Trigger while busy
        mask_a = vecs[2].mask;
        val_a  = vecs[2].vals;
        rxq.delete();
        done_cnt = 0;
        pulse_force_a();
        repeat (150) @(negedge clk);
        pulse_force_a();
        wait_done("ovr", 4000);
        repeat (10) @(negedge clk);
        check_frame("ovr_frame", vecs[2].exp);
        check_val("ovr_set", int'(ovr_a), 1);
        repeat (1500) @(negedge clk);
        check_val("ovr_done_count", done_cnt, 1);
        check_val("ovr_no_extra_bytes", rxq.size(), vecs[2].exp.len());
        check_val("ovr_sticky", int'(ovr_a), 1);

        // Reset during the third byte
        mask_a = vecs[0].mask;
        val_a  = vecs[0].vals;
        rxq.delete();
        done_cnt = 0;
        pulse_force_a();
        n = 0;
        while (rxq.size() < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("rst_two_bytes_seen", int'(rxq.size() >= 2), 1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_tx", int'(tx_a), 1);
        check_val("midrst_busy", int'(busy_a), 0);
        check_val("midrst_overrun", int'(ovr_a), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        run_vec(0);

        // Empty mask: no frame at all
        mask_a = 3'b000;
        done_cnt = 0;
        tx_low  = 1'b0;
        busy_hi = 1'b0;
        pulse_force_a();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) tx_low = 1'b1;
            if (busy_a !== 1'b0) busy_hi = 1'b1;
        end
        check_val("nomask_tx_low", int'(tx_low), 0);
        check_val("nomask_busy", int'(busy_hi), 0);
        check_val("nomask_done", done_cnt, 0);
        check_val("nomask_overrun", int'(ovr_a), 0);

        check_val("framing_errors", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_telemetry_tx.md
Name: uart_telemetry_tx

Overview:
Multi-channel telemetry transmitter that periodically formats up to NUM_CH unsigned sensor values as an ASCII line and sends it over a UART 8N1 link.
- Line format: "<tag>:<decimal>" per enabled channel, joined by ", ", terminated by "\n\r".
- Successor to the fixed humidity/temperature/distance UART controller, generalised in channel count, value width, baud and period; adds an on-demand trigger and overrun reporting.
- Sits between the sensor blocks (DHT11, ultrasonic) and the board TX pin.

Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUD, 9600: UART bit rate. Divider is floor(CLK_FREQ/BAUD).
- NUM_CH, 3: number of channels, 1..8.
- VAL_W, 10: value width per channel, 1..16. DIGITS = ceil(log10(2^VAL_W)) is a derived localparam.
- PERIOD_CLKS, 100_000_000: clocks between automatic frames (1 Hz default).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  enables the periodic trigger; force_send works regardless of enable
- force_send  in  1  one-cycle pulse; requests an immediate frame
- ch_mask  in  NUM_CH  channel include mask; bit i includes channel i
- ch_tag  in  NUM_CH*8  ASCII tag per channel; channel i occupies bits [8i+7:8i]
- ch_value  in  NUM_CH*VAL_W  unsigned value per channel
- tx  out  1  UART line, idles high
- busy  out  1  high from snapshot until the last stop bit ends
- frame_done  out  1  one-cycle pulse when the last stop bit completes
- overrun  out  1  sticky; set when a trigger arrives while busy; cleared only by reset

Behaviour:
- Reset: tx=1, busy=0, frame_done=0, overrun=0; period counter=0; FSM=IDLE. Reset mid-frame aborts the frame, and tx=1 from the next edge.
- Period counter: counts only when enable=1. Generates a trigger at PERIOD_CLKS-1, then wraps to 0.
- Trigger = period tick OR force_send. If both occur in the same cycle, treat as one trigger.
  - Trigger while busy: dropped; overrun<=1.
  - Trigger when ch_mask==0: no frame, busy stays 0, no overrun.
- FSM states:
  - IDLE: on trigger -> LOAD.
  - LOAD (1 cycle): snapshot ch_mask, ch_tag and ch_value into registers; busy<=1. Input changes after this cycle do not affect the frame.
  - SEL: find the lowest-index unsent enabled channel. If none remain -> EOL.
  - CONV: sequential binary-to-BCD (double-dabble), exactly VAL_W cycles.
  - TAG -> COLON -> DIGITS -> SEP. DIGITS suppresses leading zeros, but a value of 0 emits "0".
  - SEP emits ',' then ' ' only if another enabled channel follows; otherwise -> EOL.
  - EOL: emits 0x0A then 0x0D.
  - DONE: frame_done pulse; busy<=0; -> IDLE.
- Byte handoff: each emit state asserts start to the serializer with a byte, then waits for ready. No byte may be issued while ready=0.
- First start bit begins no later than VAL_W+4 cycles after the trigger.
- Serializer framing: start bit 0, 8 data bits LSB first, 1 stop bit. Each bit lasts exactly floor(CLK_FREQ/BAUD) clocks. Back-to-back bytes have no idle gap beyond 1 clock.

Decomposition:
- Package uart_telemetry_pkg:
  - ASCII constants: ':' 0x3A, ',' 0x2C, ' ' 0x20, LF 0x0A, CR 0x0D, '0' 0x30.
  - FSM state enum.
  - Function clog10 for DIGITS.
- Sub-module uart_tx_byte: 8N1 serializer.
  - Parameters: CLK_FREQ, BAUD.
  - Ports: clk, reset, start, data[7:0], tx, ready.
  - ready=1 in idle; start is accepted only when ready=1.

Test Plan:
1. NUM_CH=3; tags 'H','T','D'; values 58, 25, 123; mask 3'b011; force_send -> decoded tx "H:58, T:25\n\r" (12 bytes); one frame_done pulse; overrun=0.
2. mask 3'b100; value D=0 -> "D:0\n\r". Then D=1023, mask 3'b111, H=7, T=100 -> "H:7, T:100, D:1023\n\r".
3. BAUD=115200, CLK_FREQ=100 MHz -> every tx bit lasts 868 clocks. Start bit=0, stop bit=1, data LSB first, checked on byte 0x48 ('H').
4. PERIOD_CLKS=1000, enable=1 -> frames start every 1000 clocks. With enable=0 no frames start; force_send still sends exactly one frame.
5. force_send pulsed mid-frame -> frame bytes unchanged; overrun=1 and remains 1 after the frame; no second frame.
6. reset asserted during the 3rd byte -> tx=1 and busy=0 on the next edge. The next force_send produces a complete, correct frame. ch_mask=0 with force_send -> tx stays 1 and busy stays 0.
